// File: rtl/dmem_responder.sv
// dmem_responder
// Data-side responder for the processor's dmem port. It combines a
// word-addressed data RAM with a small memory-mapped I/O window at 0xF00-0xFFF.
// Read data is registered, so q_dmem appears one cycle after the address.
//
// Ports:
//   clock        - system clock, all state updates on the rising edge
//   reset        - synchronous active-high reset (RAM contents are kept)
//   address_dmem - 12-bit word address from the processor
//   data         - 32-bit write data
//   wren         - write enable, the write happens at the rising edge
//   q_dmem       - registered read data for the previously sampled address
//   led_out      - LED register (LED_W bits)
//   timer_irq    - sticky timer-expired flag
//   halt         - sticky halt flag, cleared only by reset
//
// I/O map:
//   0xF00 CYCLE (read only, value before this edge's increment)
//   0xF01 LED   0xF02 TIMER   0xF03 STAT (write data[0]=1 clears timer_irq)
//   0xF04 HALT (nonzero write sets halt)
// RAM_WORDS must be between 2 and 3840.

module dmem_responder #(
    parameter int RAM_WORDS = 1024,
    parameter int LED_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [11:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q_dmem,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq,
    output logic             halt
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [11:0] ADDR_CYCLE = 12'hF00;
    localparam logic [11:0] ADDR_LED   = 12'hF01;
    localparam logic [11:0] ADDR_TIMER = 12'hF02;
    localparam logic [11:0] ADDR_STAT  = 12'hF03;
    localparam logic [11:0] ADDR_HALT  = 12'hF04;

    logic [31:0]      mem_q [0:RAM_WORDS-1];

    logic [31:0]      q_dmem_q, q_dmem_d;
    logic [31:0]      cycle_q,  cycle_d;
    logic [LED_W-1:0] led_q,    led_d;
    logic [31:0]      timer_q,  timer_d;
    logic             irq_q,    irq_d;
    logic             halt_q,   halt_d;

    logic             in_ram_s;
    logic [AW-1:0]    ram_idx_s;
    logic             ram_we_s;
    logic             load_s;
    logic             expire_s;

    assign in_ram_s  = ({20'h0_0000, address_dmem} < 32'(RAM_WORDS));
    assign ram_idx_s = address_dmem[AW-1:0];
    // Reset suppresses a simultaneous RAM write.
    assign ram_we_s  = wren & in_ram_s & ~reset;

    assign q_dmem    = q_dmem_q;
    assign led_out   = led_q;
    assign timer_irq = irq_q;
    assign halt      = halt_q;

    // Read mux: selects RAM or I/O register using current (pre-edge) state.
    always_comb begin
        q_dmem_d = 32'h0000_0000;
        if (in_ram_s) begin
            q_dmem_d = mem_q[ram_idx_s];
        end else begin
            case (address_dmem)
                ADDR_CYCLE: q_dmem_d = cycle_q;
                ADDR_LED:   q_dmem_d = 32'(led_q);
                ADDR_TIMER: q_dmem_d = timer_q;
                ADDR_STAT:  q_dmem_d = {31'h0000_0000, irq_q};
                ADDR_HALT:  q_dmem_d = {31'h0000_0000, halt_q};
                default:    q_dmem_d = 32'h0000_0000;
            endcase
        end
    end

    // Next-state logic for the cycle counter, LED, timer and sticky flags.
    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        led_d    = led_q;
        halt_d   = halt_q;
        irq_d    = irq_q;
        load_s   = wren && (address_dmem == ADDR_TIMER);

        if (wren && (address_dmem == ADDR_LED)) begin
            led_d = data[LED_W-1:0];
        end else begin
            led_d = led_q;
        end

        if (wren && (address_dmem == ADDR_HALT) && (data != 32'h0000_0000)) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_q;
        end

        // A load wins over the decrement; count parks at zero.
        if (load_s) begin
            timer_d = data;
        end else if (timer_q != 32'h0000_0000) begin
            timer_d = timer_q - 32'd1;
        end else begin
            timer_d = timer_q;
        end

        // Expiry only on a natural 1->0 step, never on a load of 0.
        expire_s = !load_s && (timer_q == 32'd1);

        // Expiry takes priority over a same-edge STAT clear.
        if (expire_s) begin
            irq_d = 1'b1;
        end else if (wren && (address_dmem == ADDR_STAT) && data[0]) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem_q <= 32'h0000_0000;
            cycle_q  <= 32'h0000_0000;
            led_q    <= '0;
            timer_q  <= 32'h0000_0000;
            irq_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            q_dmem_q <= q_dmem_d;
            cycle_q  <= cycle_d;
            led_q    <= led_d;
            timer_q  <= timer_d;
            irq_q    <= irq_d;
            halt_q   <= halt_d;
        end
    end

    // Data RAM write port; contents survive reset. Read-first comes from the
    // read mux sampling mem_q before this write lands.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            mem_q[ram_idx_s] <= data;
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the processor's dmem port. It receives address_dmem, data and wren, and returns q_dmem with one-cycle registered read latency.
- Combines a word-addressed data RAM with a small memory-mapped I/O window at 0xF00–0xFFF: cycle counter, LED register, countdown timer with sticky expiry flag, and halt latch.
- Sits beside the regfile under the top-level skeleton. Drives board-visible LEDs, a timer interrupt line and a halt flag.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words at addresses 0x000..RAM_WORDS-1; must be ≤ 3840 (0xF00).
- LED_W, 16, width of the LED output register.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address_dmem  input  12  word address from the processor.
- data  input  32  write data from the processor.
- wren  input  1  write enable; a write is performed at the rising edge when high.
- q_dmem  output  32  registered read data for the address sampled at the previous edge.
- led_out  output  LED_W  current LED register value.
- timer_irq  output  1  sticky timer-expired flag.
- halt  output  1  sticky halt flag.

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - q_dmem=0, cycle counter=0, led_out=0, timer count=0, timer_irq=0, halt=0.
  - RAM contents are NOT cleared.
  - Reset overrides any simultaneous write.
- Cycle counter: 32-bit free-running, +1 every non-reset cycle, wraps 0xFFFFFFFF→0.
- Read path:
  - Every edge, q_dmem <= value selected by address_dmem at that edge. Latency is exactly 1 cycle.
  - A read is performed whether or not wren is high.
  - Read-during-write to the same address returns the OLD value (read-first). The new value is visible on the next read.
- Address map:
  - 0x000..RAM_WORDS-1: RAM, read/write.
  - RAM_WORDS..0xEFF: unmapped; read 0, writes ignored.
  - 0xF00 CYCLE: read returns the counter value before this edge's increment; writes ignored.
  - 0xF01 LED: write stores data[LED_W-1:0]; read returns the value zero-extended.
  - 0xF02 TIMER: write loads count=data; read returns the current count.
  - 0xF03 STAT: read returns {31'b0, timer_irq}; writing data[0]=1 clears timer_irq, data[0]=0 has no effect.
  - 0xF04 HALT: writing nonzero data sets halt, writing zero has no effect; read returns {31'b0, halt}. halt clears only on reset.
  - 0xF05..0xFFF: unmapped; read 0, writes ignored.
- Timer:
  - When not being loaded and count>0: count decrements by 1 per cycle.
  - Count transitioning 1→0 sets timer_irq at that same edge, so it is visible the following cycle.
  - Loading 0 stops the timer without setting timer_irq.
  - Loading while running restarts from the new value; the load wins over the decrement on that edge.
  - When count=0 it holds at 0 and never underflows.
  - If a STAT clear and an expiry occur on the same edge, the expiry wins and timer_irq=1.
- Outputs led_out, timer_irq and halt are registered, with no combinational path from the inputs.

Test Plan:
- Reset, then write 0x0000_0005 to 0x003, then read 0x003 → q_dmem=0x0000_0005 one cycle after the read address is presented. Reading 0x004 with no prior write → arbitrary RAM content, checked only for X-free after init.
- Write 0xDEAD_BEEF to 0x010 at edge N and read 0x010 at the same edge (old value 0x1111_1111) → q_dmem=0x1111_1111 after N, then 0xDEAD_BEEF after a re-read at N+1.
- Reset released at edge 0; read 0xF00 at edges 10 and 11 → consecutive q_dmem values differ by exactly 1. Force counter to 0xFFFF_FFFF → next read shows 0.
- Write 3 to 0xF02 → timer_irq rises exactly 3 cycles after the write edge. Write 1 to 0xF03 → timer_irq drops next cycle. Write 0 to 0xF02 → timer_irq stays 0.
- Write 0x1_ABCD to 0xF01 → led_out=0xABCD and a read of 0xF01 returns 0x0000_ABCD. Write 0xF00 or 0xF10 → no state change, reads of 0xF10 return 0.
- Write 7 to 0xF04 → halt=1. Write 0 to 0xF04 → halt stays 1. Assert reset mid-timer-countdown with a simultaneous write to 0xF01 → all outputs 0 next cycle.
